fir_mem_engine: RTL and testbench
=================================

Name: fir_mem_engine

Overview:
- Parametrised, self-contained successor to the fixed 8-bit memory-to-memory FIR runner.
- Reads signed samples from a BRAM read port, filters them through a TAPS-deep delay line using runtime-loadable coefficients, and writes saturated results to a BRAM write port.
- Takes run geometry (input/output base address, sample count) at start instead of hardcoding it.
- Includes a saturating performance counter. Sits between the test controller and the shared bram_memory.

Parameters:
- DATA_W, 8, sample and result width (signed two's complement).
- COEF_W, 8, coefficient width (signed).
- TAPS, 8, filter length, >=2.
- ADDR_W, 10, BRAM address width.
- OUT_SHIFT, 7, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  run request, sampled only in IDLE
- input_addr  in  ADDR_W  first input sample address, latched at accepted start
- output_addr  in  ADDR_W  first result address, latched at accepted start
- sample_count  in  ADDR_W  number of samples, latched at accepted start
- coef_we  in  1  coefficient write strobe
- coef_idx  in  clog2(TAPS)  coefficient index
- coef_data  in  COEF_W  coefficient value
- busy  out  1  run in progress
- done  out  1  sticky completion flag
- cycle_count  out  32  busy-cycle count of last/current run
- mem_addr_a  out  ADDR_W  read address to BRAM port A
- mem_data_out_a  in  DATA_W  BRAM port A read data, 1-cycle synchronous latency
- mem_addr_b  out  ADDR_W  write address to BRAM port B
- mem_data_in_b  out  DATA_W  write data
- mem_we_b  out  1  write enable

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, mem_we_b, mem_addr_a, mem_addr_b, mem_data_in_b, cycle_count = 0. Coefficients, delay line and accumulator = 0.
- ACC_W = DATA_W + COEF_W + clog2(TAPS). Products and accumulation are signed and full precision.
- FSM states: IDLE, FETCH, CAPTURE, MAC, WRITE.
- IDLE + start, sample_count != 0:
  - latch the three run inputs, clear delay line, n=0, done=0, cycle_count=0, busy=1.
  - next state FETCH.
- IDLE + start, sample_count == 0: done=1 next edge; busy stays 0; no memory writes; cycle_count=0.
- FETCH (1 cycle): mem_addr_a = input_addr+n, mod 2^ADDR_W. Next state CAPTURE.
- CAPTURE (1 cycle):
  - shift delay line: d[k] <= d[k-1], d[0] <= mem_data_out_a.
  - acc <= 0, tap k=0. Next state MAC.
- MAC (TAPS cycles): acc += d[k]*c[k], k = 0..TAPS-1. Next state WRITE.
- WRITE (1 cycle):
  - mem_we_b=1, mem_addr_b = output_addr+n (wraps).
  - mem_data_in_b = sat(acc >>> OUT_SHIFT), clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - n++. If n == sample_count-1 (last sample): busy=0, done=1, next state IDLE; else next state FETCH.
- Per-sample latency: TAPS+3 cycles. Total busy cycles = sample_count*(TAPS+3).
- mem_we_b is high only in WRITE. Addresses hold their last value otherwise.
- done stays high until the next accepted start or reset.
- start while busy: ignored.
- coef_we: writes c[coef_idx] only in IDLE; ignored while busy. Out-of-range idx (TAPS not a power of 2): ignored.
- cycle_count: increments each edge with busy=1, saturates at 0xFFFFFFFF, holds after completion.
- Reset mid-run: immediate return to reset values, no further writes. A subsequent start runs normally. Coefficients must be reloaded.

Optional Feature:
- Macro: FIR_ROUND_EN.
- Defined: in WRITE, adds 2^(OUT_SHIFT-1) to acc before the shift (round half up), then saturates.
- Undefined: truncating shift only. Timing is identical in both cases.

Test Plan:
- Coefficients c0=64, c1=64, others 0; input 10,20,30 at addr 0; sample_count=3; output_addr=512 -> mem[512..514] = 5,15,25; done=1; cycle_count=33.
- All coefficients 127; 8 samples of 127 -> result 8 = 127 (saturated). Repeat with -128 -> -128.
- sample_count=100, TAPS=8 -> exactly 100 mem_we_b pulses, busy low afterwards, done=1, cycle_count=1100. A start pulse mid-run has no effect.
- sample_count=0 -> done=1 one cycle after start, busy never high, no writes, cycle_count=0.
- Reset asserted after 5th write of a 100-sample run -> all outputs 0 immediately, no 6th write. Reload coefficients and restart -> full correct run.
- x=1, c0=64 -> result 0 without FIR_ROUND_EN, 1 with it. input_addr=1022, 4 samples -> reads 1022, 1023, 0, 1.

Source files
------------

// File: rtl/fir_mem_engine.sv
// rtl/fir_mem_engine.sv - memory-to-memory FIR runner with runtime coefficients and saturating output
// Build option FIR_ROUND_EN: round half up before the output shift instead of truncating.
module fir_mem_engine #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 8,
    parameter int ADDR_W    = 10,
    parameter int OUT_SHIFT = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         input_addr,
    input  logic [ADDR_W-1:0]         output_addr,
    input  logic [ADDR_W-1:0]         sample_count,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_idx,
    input  logic [COEF_W-1:0]         coef_data,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               cycle_count,
    output logic [ADDR_W-1:0]         mem_addr_a,
    input  logic [DATA_W-1:0]         mem_data_out_a,
    output logic [ADDR_W-1:0]         mem_addr_b,
    output logic [DATA_W-1:0]         mem_data_in_b,
    output logic                      mem_we_b
);
    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + IDX_W;
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef FIR_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (OUT_SHIFT - 1);
`endif

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, MAC, WRITE} state_t;

    state_t                    state;
    logic signed [COEF_W-1:0]  coef  [TAPS];
    logic signed [DATA_W-1:0]  dline [TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic [IDX_W-1:0]          tap;
    logic [ADDR_W-1:0]         in_base, out_base, count, n;

    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_next, acc_adj, acc_shr;
    logic signed [DATA_W-1:0]  sat_val;

    // Last MAC step and output conditioning are formed combinationally so the
    // result is registered straight into the write port on entry to WRITE.
    always_comb begin
        prod     = dline[tap] * coef[tap];
        acc_next = acc + ACC_W'(prod);
`ifdef FIR_ROUND_EN
        acc_adj  = acc_next + RND;
`else
        acc_adj  = acc_next;
`endif
        acc_shr  = acc_adj >>> OUT_SHIFT;
        if (acc_shr > ACC_W'(OUT_MAX))
            sat_val = OUT_MAX;
        else if (acc_shr < ACC_W'(OUT_MIN))
            sat_val = OUT_MIN;
        else
            sat_val = acc_shr[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            cycle_count   <= '0;
            mem_addr_a    <= '0;
            mem_addr_b    <= '0;
            mem_data_in_b <= '0;
            mem_we_b      <= 1'b0;
            acc           <= '0;
            tap           <= '0;
            in_base       <= '0;
            out_base      <= '0;
            count         <= '0;
            n             <= '0;
            for (int k = 0; k < TAPS; k++) begin
                coef[k]  <= '0;
                dline[k] <= '0;
            end
        end else begin
            if (busy && cycle_count != 32'hFFFF_FFFF)
                cycle_count <= cycle_count + 32'd1;

            case (state)
                IDLE: begin
                    if (coef_we && 32'(coef_idx) < TAPS)
                        coef[coef_idx] <= coef_data;
                    if (start) begin
                        cycle_count <= '0;
                        if (sample_count != '0) begin
                            in_base    <= input_addr;
                            out_base   <= output_addr;
                            count      <= sample_count;
                            n          <= '0;
                            done       <= 1'b0;
                            busy       <= 1'b1;
                            mem_addr_a <= input_addr;
                            for (int k = 0; k < TAPS; k++)
                                dline[k] <= '0;
                            state      <= FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: state <= CAPTURE;
                CAPTURE: begin
                    for (int k = TAPS - 1; k > 0; k--)
                        dline[k] <= dline[k-1];
                    dline[0] <= mem_data_out_a;
                    acc      <= '0;
                    tap      <= '0;
                    state    <= MAC;
                end
                MAC: begin
                    acc <= acc_next;
                    if (tap == IDX_W'(TAPS - 1)) begin
                        mem_we_b      <= 1'b1;
                        mem_addr_b    <= out_base + n;
                        mem_data_in_b <= sat_val;
                        state         <= WRITE;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                WRITE: begin
                    mem_we_b <= 1'b0;
                    n        <= n + 1'b1;
                    if (n == count - 1'b1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        mem_addr_a <= in_base + n + 1'b1;
                        state      <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mem_engine.sv
// tb/tb_fir_mem_engine.sv - randomized self-checking bench for fir_mem_engine against an arithmetic FIR model
module tb_fir_mem_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  input_addr, output_addr, sample_count;
    logic        coef_we;
    logic [2:0]  coef_idx;
    logic [7:0]  coef_data;
    logic        busy, done;
    logic [31:0] cycle_count;
    logic [9:0]  mem_addr_a, mem_addr_b;
    logic [7:0]  mem_data_out_a, mem_data_in_b;
    logic        mem_we_b;

    fir_mem_engine dut (
        .clk(clk), .rst(rst), .start(start),
        .input_addr(input_addr), .output_addr(output_addr), .sample_count(sample_count),
        .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
        .busy(busy), .done(done), .cycle_count(cycle_count),
        .mem_addr_a(mem_addr_a), .mem_data_out_a(mem_data_out_a),
        .mem_addr_b(mem_addr_b), .mem_data_in_b(mem_data_in_b), .mem_we_b(mem_we_b)
    );

    always #5 clk = ~clk;

    logic signed [7:0] src [1024];
    logic signed [7:0] dst [1024];
    int wr_total = 0;

    always @(posedge clk) begin
        mem_data_out_a <= src[mem_addr_a];
        if (mem_we_b) begin
            dst[mem_addr_b] <= mem_data_in_b;
            wr_total        <= wr_total + 1;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int rc [8];

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int ia, input int j);
        int acc = 0;
        for (int k = 0; k < 8; k++)
            if (j - k >= 0)
                acc += rc[k] * int'(src[(ia + j - k) % 1024]);
`ifdef FIR_ROUND_EN
        acc += 64;
`endif
        acc = acc >>> 7;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return acc;
    endfunction

    task automatic load_coefs();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            coef_we   = 1'b1;
            coef_idx  = 3'(k);
            coef_data = 8'(rc[k]);
        end
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic start_run(input int ia, input int oa, input int cnt);
        @(negedge clk);
        input_addr   = 10'(ia);
        output_addr  = 10'(oa);
        sample_count = 10'(cnt);
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int i = 0;
        while (!done && i < bound) begin
            @(negedge clk);
            i++;
        end
        if (!done) check("timeout_done", done, 1);
    endtask

    task automatic check_results(input string tag, input int ia, input int oa, input int cnt, input int w0);
        for (int j = 0; j < cnt; j++)
            check($sformatf("%s_y%0d", tag, j), dst[(oa + j) % 1024], model(ia, j));
        check({tag, "_writes"}, wr_total - w0, cnt);
        check({tag, "_cycles"}, cycle_count, cnt * 11);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 1);
    endtask

    task automatic do_run(input string tag, input int ia, input int oa, input int cnt);
        int w0 = wr_total;
        start_run(ia, oa, cnt);
        wait_done(cnt * 11 + 20);
        check_results(tag, ia, oa, cnt, w0);
    endtask

    task automatic rand_coefs();
        for (int k = 0; k < 8; k++) rc[k] = int'($urandom_range(255)) - 128;
    endtask

    initial begin
        int w0, busy_seen, ia, oa, cnt;
        rst = 1'b1; start = 1'b0; coef_we = 1'b0; coef_idx = '0; coef_data = '0;
        input_addr = '0; output_addr = '0; sample_count = '0;
        for (int i = 0; i < 1024; i++) src[i] = 8'($urandom_range(255));
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", mem_we_b, 0);
        check("rst_addr_a", mem_addr_a, 0);
        check("rst_addr_b", mem_addr_b, 0);
        check("rst_data_b", mem_data_in_b, 0);
        check("rst_cycles", cycle_count, 0);
        rst = 1'b0;

        // zero-length run
        w0 = wr_total;
        busy_seen = 0;
        start_run(5, 5, 0);
        check("zero_done", done, 1);
        for (int i = 0; i < 6; i++) begin
            if (busy) busy_seen++;
            @(negedge clk);
        end
        check("zero_busy_seen", busy_seen, 0);
        check("zero_writes", wr_total - w0, 0);
        check("zero_cycles", cycle_count, 0);

        // directed two-tap average
        rc = '{64, 64, 0, 0, 0, 0, 0, 0};
        load_coefs();
        src[0] = 8'sd10; src[1] = 8'sd20; src[2] = 8'sd30;
        w0 = wr_total;
        start_run(0, 512, 3);
        wait_done(60);
        check("avg_y0", dst[512], 5);
        check("avg_y1", dst[513], 15);
        check("avg_y2", dst[514], 25);
        check("avg_cycles", cycle_count, 33);
        check("avg_writes", wr_total - w0, 3);
        check("avg_done", done, 1);

        // saturation both ways
        rc = '{127, 127, 127, 127, 127, 127, 127, 127};
        load_coefs();
        for (int i = 100; i < 108; i++) src[i] = 8'sd127;
        do_run("satp", 100, 600, 8);
        check("satp_last", dst[607], 127);
        for (int i = 100; i < 108; i++) src[i] = -8'sd128;
        do_run("satn", 100, 600, 8);
        check("satn_last", dst[607], -128);

        // rounding corner
        rc = '{64, 0, 0, 0, 0, 0, 0, 0};
        load_coefs();
        src[200] = 8'sd1;
`ifdef FIR_ROUND_EN
        do_run("round", 200, 700, 1);
        check("round_y", dst[700], 1);
`else
        do_run("round", 200, 700, 1);
        check("round_y", dst[700], 0);
`endif

        // read address wrap with distinct samples
        rand_coefs();
        load_coefs();
        src[1022] = 8'sd17; src[1023] = -8'sd45; src[0] = 8'sd99; src[1] = -8'sd7;
        do_run("wrap", 1022, 1021, 4);

        // randomized geometry and coefficients
        for (int r = 0; r < 6; r++) begin
            rand_coefs();
            load_coefs();
            ia  = int'($urandom_range(1023));
            oa  = int'($urandom_range(1023));
            cnt = int'($urandom_range(24, 1));
            do_run($sformatf("rnd%0d", r), ia, oa, cnt);
        end

        // long run, stray start and coefficient write while busy
        rand_coefs();
        load_coefs();
        w0 = wr_total;
        start_run(300, 0, 100);
        repeat (50) @(negedge clk);
        start = 1'b1; input_addr = 10'd0; sample_count = 10'd5;
        coef_we = 1'b1; coef_idx = 3'd0; coef_data = 8'(rc[0] + 1);
        @(negedge clk);
        start = 1'b0; coef_we = 1'b0;
        wait_done(1200);
        check_results("long", 300, 0, 100, w0);
        repeat (3) @(negedge clk);
        check("long_hold_cycles", cycle_count, 1100);

        // reset in the middle of a run
        rand_coefs();
        load_coefs();
        w0 = wr_total;
        start_run(0, 100, 100);
        for (int i = 0; i < 200 && (wr_total - w0) < 5; i++) @(negedge clk);
        check("mid_five_writes", wr_total - w0, 5);
        rst = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_we", mem_we_b, 0);
        check("mid_addr_a", mem_addr_a, 0);
        check("mid_addr_b", mem_addr_b, 0);
        check("mid_data_b", mem_data_in_b, 0);
        check("mid_cycles", cycle_count, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_no_sixth", wr_total - w0, 5);
        rc = '{0, 0, 0, 0, 0, 0, 0, 0};
        do_run("cleared", 40, 800, 6);
        rand_coefs();
        load_coefs();
        do_run("restart", 0, 100, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
